// File: rtl/simple_uart_rx_pkg.sv
// uart_pkg: shared UART types, bit timing and register map constants.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int TICKS_PER_BIT = 3;
    localparam int SAMPLE_SUB = 1;
    localparam logic [1:0] ODR = 2'd0;
    localparam logic [1:0] IDR = 2'd1;
    localparam logic [1:0] BSR = 2'd2;
    localparam logic [1:0] SR = 2'd3;
    localparam int SR_TX_BUSY = 0;
    localparam int SR_RX_VALID = 1;
    localparam int SR_OVERRUN = 2;
    localparam int SR_FRAME_ERR = 3;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/simple_uart_rx_if.sv
// simple_uart_rx_if: register-side read path and status of the UART receiver.
interface simple_uart_rx_if #(parameter int CW = 3);
    logic rd_i;
    logic clr_err_i;
    logic [7:0] data_o;
    logic valid_o;
    logic [CW-1:0] count_o;
    logic overrun_o;
    logic frame_err_o;
    modport master(input rd_i, clr_err_i, output data_o, valid_o, count_o, overrun_o, frame_err_o);
    modport slave(output rd_i, clr_err_i, input data_o, valid_o, count_o, overrun_o, frame_err_o);
endinterface

// File: rtl/simple_uart_rx_fifo.sv
// uart_byte_fifo: first-word fall-through byte FIFO; head reads as 0 when empty.
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic full_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic empty, do_pop, do_push;
    assign empty = cnt == '0;
    assign full_o = cnt == CW'(DEPTH);
    assign do_pop = pop_i && !empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o = empty ? 8'd0 : mem[rd_ptr];
    assign count_o = cnt;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk_i)
        if (do_push) mem[wr_ptr] <= din_i;
endmodule

// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 receiver on the shared 3x baud tick, feeding a byte FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting per bit instead of one mid-bit sample.
module simple_uart_rx
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    input  logic [31:0] bsr_i,
    simple_uart_rx_if.master bus
);
    logic [1:0] sync;
    logic rxd_s, tick, last_sub, decide, smp, push, bad_stop, full, ovf;
    logic [31:0] cnt;
    rx_state_t state, state_n;
    logic [1:0] sub, sub_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n, fifo_data;
    logic [CW-1:0] fifo_count;
    logic overrun, frame_err;
    assign rxd_s = sync[1];
    assign tick = cnt >= bsr_i;
    assign last_sub = sub == 2'(TICKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) vote <= 2'b11;
        else if (tick) vote <= (state == IDLE || sub == 2'd0) ? {vote[1], rxd_s} : (sub == 2'd1) ? {rxd_s, vote[0]} : vote;
    end
    assign smp = maj3(vote[0], vote[1], rxd_s);
    assign decide = last_sub;
`else
    assign smp = rxd_s;
    assign decide = sub == 2'(SAMPLE_SUB);
`endif
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync <= 2'b11;
            cnt <= 32'd0;
            state <= IDLE;
            sub <= 2'd0;
            bit_idx <= 3'd0;
            shift <= 8'd0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync <= {sync[0], rxd_i};
            cnt <= tick ? 32'd0 : cnt + 32'd1;
            state <= state_n;
            sub <= sub_n;
            bit_idx <= bit_idx_n;
            shift <= shift_n;
            overrun <= ovf | (overrun & ~bus.clr_err_i);
            frame_err <= bad_stop | (frame_err & ~bus.clr_err_i);
        end
    end
    // sub holds the index of the upcoming tick; the start-detect tick is sub 0 of START
    always_comb begin
        state_n = state;
        sub_n = sub;
        bit_idx_n = bit_idx;
        shift_n = shift;
        push = 1'b0;
        bad_stop = 1'b0;
        if (tick) begin
            sub_n = last_sub ? 2'd0 : sub + 2'd1;
            case (state)
                IDLE: begin
                    state_n = rxd_s ? IDLE : START;
                    sub_n = 2'd1;
                    bit_idx_n = 3'd0;
                end
                START: state_n = (decide && smp) ? IDLE : last_sub ? DATA : START;
                DATA: begin
                    if (decide) shift_n[bit_idx] = smp;
                    if (last_sub) begin
                        bit_idx_n = bit_idx + 3'd1;
                        state_n = (bit_idx == 3'd7) ? STOP : DATA;
                    end
                end
                default: if (decide) begin
                    state_n = IDLE;
                    push = smp;
                    bad_stop = !smp;
                end
            endcase
        end
    end
    assign ovf = push && full && !bus.rd_i;
    uart_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push_i(push),
        .pop_i(bus.rd_i),
        .din_i(shift),
        .dout_o(fifo_data),
        .full_o(full),
        .count_o(fifo_count)
    );
    assign bus.data_o = fifo_data;
    assign bus.valid_o = fifo_count != '0;
    assign bus.count_o = fifo_count;
    assign bus.overrun_o = overrun;
    assign bus.frame_err_o = frame_err;
endmodule

// File: tb/tb_simple_uart_rx.sv
// tb_simple_uart_rx: scoreboard bench for simple_uart_rx at bsr_i=2 (9 clocks per bit).
module tb_simple_uart_rx;
    localparam int DEPTH = 4;
`ifdef UART_RX_MAJORITY_EN
    localparam int PUSH_TICKS = 29;
`else
    localparam int PUSH_TICKS = 28;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic [31:0] bsr = 32'd2;
    int pcnt = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic exp_ovr = 1'b0;
    logic pre_valid, post_valid;
    logic [2:0] post_count;
    logic [7:0] post_data;
    simple_uart_rx_if #(.CW(3)) bus();
    simple_uart_rx #(.DEPTH(DEPTH), .CW(3)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .rxd_i(rxd),
        .bsr_i(bsr),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    // Ticks land on posedges base+3, base+6, ...; the push edge follows from the detect tick.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_push, input int nclk);
        logic [9:0] bits;
        logic [7:0] exp;
        int p, x, pe;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        p = pcnt;
        x = p + 3;
        while ((x - base) % 3 != 0) x++;
        pe = x + 3 * PUSH_TICKS;
        for (int c = 0; c < nclk || (nclk == 90 && pcnt < pe); c++) begin
            if (c > 0) @(negedge clk);
            if (pcnt == pe - 1) begin
                pre_valid = bus.valid_o;
                if (rd_at_push) begin
                    exp = q.pop_front();
                    checks++;
                    if (bus.data_o !== exp) begin errors++; $display("FAIL coincident_pop got %02h want %02h", bus.data_o, exp); end
                end
            end
            if (pcnt == pe) begin
                post_valid = bus.valid_o;
                post_count = bus.count_o;
                post_data = bus.data_o;
            end
            bus.rd_i = rd_at_push && pcnt == pe - 1;
            rxd = (c < nclk) ? bits[c/9] : 1'b1;
        end
        bus.rd_i = 1'b0;
        if (nclk == 90 && stop) begin
            if (q.size() < DEPTH) q.push_back(b);
            else exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_byte(input string tag);
        logic [7:0] exp;
        @(negedge clk);
        exp = (q.size() > 0) ? q.pop_front() : 8'h00;
        checks++;
        if (bus.data_o !== exp) begin errors++; $display("FAIL %s_pop got %02h want %02h", tag, bus.data_o, exp); end
        bus.rd_i = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.clr_err_i = 1'b1;
        @(negedge clk);
        bus.clr_err_i = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %02h want 00", bus.data_o); end
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid_o); end
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count_o); end
        if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", bus.overrun_o); end
        if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", bus.frame_err_o); end
        rst_n = 1'b1;
        base = pcnt;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus.valid_o); end
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 1'b0, 90);
        checks += 4;
        if (pre_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b want 0", pre_valid); end
        if (post_valid !== 1'b1) begin errors++; $display("FAIL basic_post_valid got %b want 1", post_valid); end
        if (post_count !== 3'd1) begin errors++; $display("FAIL basic_post_count got %0d want 1", post_count); end
        if (post_data !== 8'h55) begin errors++; $display("FAIL basic_post_data got %02h want 55", post_data); end
        pop_byte("basic");
        checks += 2;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty_valid got %b want 0", bus.valid_o); end
        if (bus.data_o !== 8'h00) begin errors++; $display("FAIL basic_empty_data got %02h want 00", bus.data_o); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1, 1'b0, 90);
        send_frame(8'hFF, 1'b1, 1'b0, 90);
        send_frame(8'hA5, 1'b1, 1'b0, 90);
        repeat (5) @(negedge clk);
        checks += 2;
        if (bus.count_o !== 3'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", bus.count_o); end
        if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL b2b_frame_err got %b want 0", bus.frame_err_o); end
        repeat (3) pop_byte("b2b");
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        checks += 2;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", bus.count_o); end
        if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL glitch_frame_err got %b want 0", bus.frame_err_o); end
        send_frame(8'h5A, 1'b1, 1'b0, 90);
        pop_byte("glitch_recover");
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, 1'b0, 90);
        @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        checks += 2;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL ferr_count got %0d want 0", bus.count_o); end
        if (bus.frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", bus.frame_err_o); end
        clear_err();
        checks++;
        if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", bus.frame_err_o); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 90);
        repeat (5) @(negedge clk);
        checks += 2;
        if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovr_count got %0d want 4", bus.count_o); end
        if (bus.overrun_o !== exp_ovr) begin errors++; $display("FAIL ovr_flag got %b want %b", bus.overrun_o, exp_ovr); end
        repeat (4) pop_byte("ovr");
        clear_err();
        checks++;
        if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", bus.overrun_o); end
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 90);
        send_frame(8'h05, 1'b1, 1'b1, 90);
        repeat (5) @(negedge clk);
        checks += 2;
        if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovr_rd_count got %0d want 4", bus.count_o); end
        if (bus.overrun_o !== exp_ovr) begin errors++; $display("FAIL ovr_rd_flag got %b want %b", bus.overrun_o, exp_ovr); end
        repeat (4) pop_byte("ovr_rd");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 1'b1, 1'b0, 90);
        send_frame(8'h81, 1'b1, 1'b0, 40);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (bus.data_o !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %02h want 00", bus.data_o); end
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", bus.valid_o); end
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", bus.count_o); end
        if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun got %b want 0", bus.overrun_o); end
        if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_err got %b want 0", bus.frame_err_o); end
        q.delete();
        exp_ovr = 1'b0;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = pcnt;
        repeat (20) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b0, 90);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.count_o !== 3'd1) begin errors++; $display("FAIL post_rst_count got %0d want 1", bus.count_o); end
        pop_byte("post_rst");
    endtask

    initial begin
        bus.rd_i = 1'b0;
        bus.clr_err_i = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
